mdu_iterative: RTL and testbench

- Parametrised multi-cycle multiply/divide unit that gives the pipelined MIPS core MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI and MTLO.
- Owns the architectural HI/LO registers.
- Sits beside the ALU in the EX stage and is started by the EX-stage control.
- Raises busy so the hazard logic can stall IF/ID/EX while an operation runs.
- Iterative datapath: one shift-add or restoring-subtract step per cycle.

---
 rtl/mdu_pkg.sv | 17 +
 rtl/mdu_iterative.sv | 219 +++++++++++++++++++++
 tb/tb_mdu_iterative.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   OP_*    : operation encodings driven by the EX-stage control.
//   state_e : control FSM states (idle, stepping, final write-back).
package mdu_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StFin  = 2'b10
  } state_e;

endpackage

// File: rtl/mdu_iterative.sv
// Iterative multiply/divide unit owning the architectural HI/LO registers.
// One shift-add (multiply) or restoring-subtract (divide) step per cycle; result
// written to HI/LO DATA_WIDTH+1 edges after the launching edge.
// Ports:
//   clk, reset (async, active-low)
//   start, op, a, b    : launch request (sampled in idle only), operation, operands
//   flush              : abort the in-flight operation
//   mthi_we, mtlo_we,
//   wdata              : direct HI/LO writes, honoured in idle when start is low
//   busy               : operation in progress (run or final cycle)
//   done, div_by_zero  : one-cycle pulses following the HI/LO update
//   hi, lo             : HI/LO register outputs
module mdu_iterative
  import mdu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  flush,
  input  logic                  mthi_we,
  input  logic                  mtlo_we,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  div_by_zero,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  localparam int unsigned W    = DATA_WIDTH;
  localparam int unsigned CntW = $clog2(DATA_WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(W - 1);

  state_e state_q, state_d;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      op_q, op_d;
  logic [2*W-1:0]  acc_q, acc_d;    // partial product / {remainder, dividend+quotient}
  logic [W-1:0]    opnd_q, opnd_d;  // multiplicand or divisor magnitude
  logic            neg_q, neg_d;    // negate product / quotient at write-back
  logic            rem_neg_q, rem_neg_d;
  logic            dbz_q, dbz_d;
  logic [W-1:0]    hi_q, hi_d, lo_q, lo_d;
  logic            done_q, done_d, dbz_out_q, dbz_out_d;

  logic launch, step, finish, mt_ok;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start && !flush) state_d = StRun;
      StRun: begin
        if (flush)                  state_d = StIdle;
        else if (cnt_q == LastCnt)  state_d = StFin;
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // ---------------- FSM: outputs / strobes ----------------
  always_comb begin
    busy   = 1'b0;
    launch = 1'b0;
    step   = 1'b0;
    finish = 1'b0;
    mt_ok  = 1'b0;
    unique case (state_q)
      StIdle: begin
        launch = start & ~flush;
        mt_ok  = ~start;
      end
      StRun: begin
        busy = 1'b1;
        step = ~flush;
      end
      StFin: begin
        busy   = 1'b1;
        finish = ~flush;
      end
      default: ;
    endcase
  end

  // ---------------- datapath ----------------
  logic          is_div, signed_op, a_neg, b_neg, b_zero;
  logic [W-1:0]  a_mag, b_mag;
  logic [W:0]    add_sum, rem_shift, rem_diff;
  logic [2*W-1:0] mul_next, div_next, prod;
  logic [W-1:0]  quo, rem;

  assign is_div = (op_q == OP_DIV) || (op_q == OP_DIVU);

  always_comb begin
    signed_op = (op == OP_MULT) || (op == OP_DIV);
    a_neg     = signed_op & a[W-1];
    b_neg     = signed_op & b[W-1];
    // |MIN| comes out as 2^(W-1), which is exact when read as unsigned.
    a_mag     = a_neg ? (~a + 1'b1) : a;
    b_mag     = b_neg ? (~b + 1'b1) : b;
    b_zero    = (b == '0);

    // Multiply: add multiplicand into the upper half when the multiplier LSB is set.
    add_sum   = {1'b0, acc_q[2*W-1:W]} + {1'b0, (acc_q[0] ? opnd_q : {W{1'b0}})};
    mul_next  = {add_sum, acc_q[W-1:1]};

    // Divide: shift in the next dividend bit and try the subtraction.
    rem_shift = acc_q[2*W-1:W-1];
    rem_diff  = rem_shift - {1'b0, opnd_q};
    div_next  = {(rem_diff[W] ? rem_shift[W-1:0] : rem_diff[W-1:0]),
                 acc_q[W-2:0], ~rem_diff[W]};

    prod = neg_q     ? (~acc_q + 1'b1)          : acc_q;
    quo  = neg_q     ? (~acc_q[W-1:0] + 1'b1)   : acc_q[W-1:0];
    rem  = rem_neg_q ? (~acc_q[2*W-1:W] + 1'b1) : acc_q[2*W-1:W];
  end

  always_comb begin
    cnt_d     = cnt_q;
    op_d      = op_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    dbz_d     = dbz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dbz_out_d = 1'b0;

    if (launch) begin
      op_d  = op;
      cnt_d = '0;
      if (op[1]) begin
        // Divide by zero runs the raw dividend through unchanged: the quotient
        // fills with ones and the remainder ends up equal to a.
        dbz_d     = b_zero;
        acc_d     = {{W{1'b0}}, (b_zero ? a : a_mag)};
        opnd_d    = b_mag;
        neg_d     = ~b_zero & (a_neg ^ b_neg);
        rem_neg_d = ~b_zero & a_neg;
      end else begin
        dbz_d     = 1'b0;
        acc_d     = {{W{1'b0}}, b_mag};
        opnd_d    = a_mag;
        neg_d     = a_neg ^ b_neg;
        rem_neg_d = 1'b0;
      end
    end

    if (step) begin
      acc_d = is_div ? div_next : mul_next;
      if (cnt_q != LastCnt) cnt_d = cnt_q + 1'b1;
    end

    if (finish) begin
      if (is_div) begin
        hi_d = rem;
        lo_d = quo;
      end else begin
        hi_d = prod[2*W-1:W];
        lo_d = prod[W-1:0];
      end
      done_d    = 1'b1;
      dbz_out_d = dbz_q;
    end

    if (mt_ok) begin
      if (mthi_we) hi_d = wdata;
      if (mtlo_we) lo_d = wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      op_q      <= OP_MULT;
      acc_q     <= '0;
      opnd_q    <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      dbz_q     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dbz_out_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      dbz_q     <= dbz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dbz_out_q <= dbz_out_d;
    end
  end

  assign hi          = hi_q;
  assign lo          = lo_q;
  assign done        = done_q;
  assign div_by_zero = dbz_out_q;

endmodule

// File: tb/tb_mdu_iterative.sv
// Self-checking bench for mdu_iterative (DATA_WIDTH=32): a transaction-level
// model compared every cycle, plus directed operations with literal results.
module tb_mdu_iterative;
  import mdu_pkg::*;

  localparam int unsigned W = 32;

  logic          clk = 1'b0;
  logic          reset, start, flush, mthi_we, mtlo_we;
  logic [1:0]    op;
  logic [W-1:0]  a, b, wdata;
  logic          busy, done, div_by_zero;
  logic [W-1:0]  hi, lo;

  int checks = 0;
  int errors = 0;
  bit checking = 1'b0;

  always #5 clk = ~clk;

  mdu_iterative #(.DATA_WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .a          (a),
    .b          (b),
    .flush      (flush),
    .mthi_we    (mthi_we),
    .mtlo_we    (mtlo_we),
    .wdata      (wdata),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero),
    .hi         (hi),
    .lo         (lo)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Architectural result {div_by_zero, hi, lo} from plain arithmetic.
  function automatic logic [64:0] model_op(input logic [1:0] f_op, input logic [31:0] x,
                                           input logic [31:0] y);
    longint sx, sy;
    logic [63:0] r;
    logic [31:0] q, m;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (f_op)
      OP_MULT:  r = 64'(sx * sy);
      OP_MULTU: r = {32'b0, x} * {32'b0, y};
      OP_DIV: begin
        if (y == 0) return {1'b1, x, 32'hFFFF_FFFF};
        q = 32'(sx / sy);
        m = 32'(sx % sy);
        r = {m, q};
      end
      default: begin
        if (y == 0) return {1'b1, x, 32'hFFFF_FFFF};
        r = {x % y, x / y};
      end
    endcase
    return {1'b0, r};
  endfunction

  // Transaction model: result lands W+1 edges after the accepting edge.
  logic          m_busy, m_done, m_dbz;
  logic [W-1:0]  m_hi, m_lo;
  logic [64:0]   m_res;
  int            m_left;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_dbz <= 1'b0;
      m_hi <= '0; m_lo <= '0; m_left <= 0; m_res <= '0;
    end else begin
      m_done <= 1'b0;
      m_dbz  <= 1'b0;
      if (!m_busy) begin
        if (start && !flush) begin
          m_res  <= model_op(op, a, b);
          m_busy <= 1'b1;
          m_left <= W;
        end else if (!start) begin
          if (mthi_we) m_hi <= wdata;
          if (mtlo_we) m_lo <= wdata;
        end
      end else if (flush) begin
        m_busy <= 1'b0;
      end else if (m_left == 0) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_dbz  <= m_res[64];
        m_hi   <= m_res[63:32];
        m_lo   <= m_res[31:0];
      end else begin
        m_left <= m_left - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("cyc busy", 64'(busy), 64'(m_busy));
      chk("cyc done", 64'(done), 64'(m_done));
      chk("cyc dbz",  64'(div_by_zero), 64'(m_dbz));
      chk("cyc hi",   64'(hi), 64'(m_hi));
      chk("cyc lo",   64'(lo), 64'(m_lo));
    end
  end

  task automatic run_op(input logic [1:0] t_op, input logic [31:0] ta, input logic [31:0] tb,
                        input logic [31:0] eh, input logic [31:0] el, input logic ed,
                        input string name);
    int nbusy = 0;
    bit seen = 1'b0;
    @(posedge clk); #2;
    start = 1'b1; op = t_op; a = ta; b = tb;
    @(posedge clk); #2;
    start = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else if (busy) nbusy++;
    end
    chk({name, " done seen"}, 64'(seen), 64'd1);
    chk({name, " busy cycles"}, 64'(nbusy), 64'd33);
    chk({name, " hi"}, 64'(hi), 64'(eh));
    chk({name, " lo"}, 64'(lo), 64'(el));
    chk({name, " dbz"}, 64'(div_by_zero), 64'(ed));
    @(negedge clk);
    chk({name, " done width"}, 64'(done), 64'd0);
  endtask

  initial begin
    bit seen;
    reset = 1'b1; start = 1'b0; flush = 1'b0; mthi_we = 1'b0; mtlo_we = 1'b0;
    op = OP_MULT; a = '0; b = '0; wdata = '0;
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset hi", 64'(hi), 64'd0);
    chk("reset lo", 64'(lo), 64'd0);
    @(posedge clk); #2 reset = 1'b1;
    checking = 1'b1;

    run_op(OP_MULT,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, "mult");
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, "multu");
    run_op(OP_MULT,  32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 1'b0, "mult min");
    run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, "div neg");
    run_op(OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, "div negb");
    run_op(OP_DIVU,  32'hFFFF_FFFF, 32'h10,       32'h0000_000F, 32'h0FFF_FFFF, 1'b0, "divu big");
    run_op(OP_DIV,   32'd5,         32'd0,        32'd5,         32'hFFFF_FFFF, 1'b1, "div zero");
    run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        32'h8000_0000, 1'b0, "div wrap");
    run_op(OP_DIVU,  32'd7,         32'd2,        32'd1,         32'd3,         1'b0, "divu");

    // Preload HI/LO, then a launched op that is squashed.
    @(posedge clk); #2;
    mthi_we = 1'b1; mtlo_we = 1'b1; wdata = 32'h1234;
    @(posedge clk); #2;
    mthi_we = 1'b0; mtlo_we = 1'b0;
    @(negedge clk);
    chk("preload hi", 64'(hi), 64'h1234);
    chk("preload lo", 64'(lo), 64'h1234);

    @(posedge clk); #2;
    start = 1'b1; op = OP_MULT; a = 32'd3; b = 32'd5;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    start = 1'b1; op = OP_DIVU; a = 32'd100; b = 32'd3; mthi_we = 1'b1; wdata = 32'hDEAD;
    @(posedge clk); #2;
    start = 1'b0; mthi_we = 1'b0;
    repeat (4) @(posedge clk);
    #2 flush = 1'b1;
    @(posedge clk); #2 flush = 1'b0;
    @(negedge clk);
    chk("flush busy", 64'(busy), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("flush no done", 64'(seen), 64'd0);
    chk("flush hi", 64'(hi), 64'h1234);
    chk("flush lo", 64'(lo), 64'h1234);

    // Start together with flush in idle is dropped.
    @(posedge clk); #2;
    start = 1'b1; flush = 1'b1; op = OP_MULT; a = 32'd9; b = 32'd9;
    @(posedge clk); #2;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("start+flush busy", 64'(busy), 64'd0);

    run_op(OP_MULTU, 32'd11, 32'd13, 32'd0, 32'd143, 1'b0, "multu small");

    // Asynchronous reset in the middle of a run.
    @(posedge clk); #2;
    start = 1'b1; op = OP_MULT; a = 32'd5; b = 32'd5;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("async busy", 64'(busy), 64'd0);
    chk("async done", 64'(done), 64'd0);
    chk("async hi", 64'(hi), 64'd0);
    chk("async lo", 64'(lo), 64'd0);
    @(posedge clk); #2 reset = 1'b1;

    run_op(OP_MULT, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, "mult after reset");

    repeat (3) @(negedge clk);
    checking = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard bound in case the sequence stalls.
  initial begin
    #200000;
    $display("FAIL timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
